// File: rtl/bpu_gshare_dual.sv
// bpu_gshare_dual: dual-issue gshare predictor with sequential table init and same-index update merging.
// Optional BPU_STATS_EN adds saturating update/mispredict counters.
module bpu_gshare_dual #(
  parameter int PC_W  = 8,
  parameter int IDX_W = 8,
  parameter int CTR_W = 2,
  parameter int GHR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc1,
  input  logic [PC_W-1:0]  pc2,
  input  logic [PC_W-1:0]  pc_f,
  output logic             pred1,
  output logic             pred2,
  output logic             pred_f,
  output logic [GHR_W-1:0] ghr_out,
  input  logic             upd1_en,
  input  logic [PC_W-1:0]  upd1_pc,
  input  logic [GHR_W-1:0] upd1_ghr,
  input  logic             upd1_taken,
  input  logic             upd2_en,
  input  logic [PC_W-1:0]  upd2_pc,
  input  logic [GHR_W-1:0] upd2_ghr,
  input  logic             upd2_taken,
  output logic             ready
`ifdef BPU_STATS_EN
  ,
  output logic [15:0]      stat_upd,
  output logic [15:0]      stat_mis
`endif
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] INIT_V = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CMAX = '1;
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CTR_W-1:0] tbl_q [DEPTH];
  logic run, e1, e2, same;
  logic [IDX_W-1:0] idx1, idx2;
  logic [CTR_W-1:0] c1, c2, n1, n2;
  logic [GHR_W:0] sh1;
  logic [GHR_W+1:0] sh2;
  function automatic logic [IDX_W-1:0] idx(input logic [PC_W-1:0] pc, input logic [GHR_W-1:0] g);
    logic [IDX_W-1:0] z;
    z = '0;
    z[GHR_W-1:0] = g;
    return pc[IDX_W-1:0] ^ z;
  endfunction
  function automatic logic [CTR_W-1:0] step(input logic [CTR_W-1:0] c, input logic t);
    return t ? ((c == CMAX) ? c : c + 1'b1) : ((c == '0) ? c : c - 1'b1);
  endfunction
  assign run  = (state_q == RUN);
  assign e1   = run & upd1_en;
  assign e2   = run & upd2_en;
  assign idx1 = idx(upd1_pc, upd1_ghr);
  assign idx2 = idx(upd2_pc, upd2_ghr);
  assign same = e1 & e2 & (idx1 == idx2);
  // slot 2 steps from slot 1's result when both hit one entry, giving a single merged write
  assign c1 = tbl_q[idx1];
  assign n1 = step(c1, upd1_taken);
  assign c2 = same ? n1 : tbl_q[idx2];
  assign n2 = step(c2, upd2_taken);
  assign pred1   = run & tbl_q[idx(pc1, ghr_q)][CTR_W-1];
  assign pred2   = run & tbl_q[idx(pc2, ghr_q)][CTR_W-1];
  assign pred_f  = run & tbl_q[idx(pc_f, ghr_q)][CTR_W-1];
  assign ghr_out = ghr_q;
  always_comb begin
    sh1   = {ghr_q, e1 ? upd1_taken : upd2_taken};
    sh2   = {ghr_q, upd1_taken, upd2_taken};
    ghr_d = (e1 & e2) ? sh2[GHR_W-1:0] : (e1 | e2) ? sh1[GHR_W-1:0] : ghr_q;
  end
  always_ff @(posedge clk) begin
    if (!run) begin
      tbl_q[ptr_q] <= INIT_V;
    end else begin
      if (e1 && !same) tbl_q[idx1] <= n1;
      if (e2) tbl_q[idx2] <= n2;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      ready   <= 1'b0;
    end else begin
      ghr_q <= ghr_d;
      if (state_q == INIT) begin
        ptr_q <= ptr_q + 1'b1;
        if (&ptr_q) begin
          state_q <= RUN;
          ready   <= 1'b1;
        end
      end
    end
  end
`ifdef BPU_STATS_EN
  logic [15:0] stat_upd_q, stat_upd_d, stat_mis_q, stat_mis_d;
  logic [16:0] upd_sum, mis_sum;
  logic m1, m2;
  always_comb begin
    m1         = e1 & (upd1_taken != c1[CTR_W-1]);
    m2         = e2 & (upd2_taken != c2[CTR_W-1]);
    upd_sum    = {1'b0, stat_upd_q} + {16'd0, e1} + {16'd0, e2};
    mis_sum    = {1'b0, stat_mis_q} + {16'd0, m1} + {16'd0, m2};
    stat_upd_d = upd_sum[16] ? 16'hFFFF : upd_sum[15:0];
    stat_mis_d = mis_sum[16] ? 16'hFFFF : mis_sum[15:0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end
  assign stat_upd = stat_upd_q;
  assign stat_mis = stat_mis_q;
`endif
endmodule

// File: tb/tb_bpu_gshare_dual.sv
// tb_bpu_gshare_dual: randomized and directed checks of bpu_gshare_dual against a table/history model.
module tb_bpu_gshare_dual;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] pc1, pc2, pc_f, upd1_pc, upd2_pc;
  logic [5:0] upd1_ghr, upd2_ghr, ghr_out;
  logic upd1_en, upd2_en, upd1_taken, upd2_taken, pred1, pred2, pred_f, ready;
  logic [3:0] n_pc1, n_pc2, n_pcf, n_u1pc, n_u2pc;
  logic [0:0] n_u1g, n_u2g, n_ghr;
  logic n_u1en, n_u2en, n_u1t, n_u2t, n_p1, n_p2, n_pf, n_ready;
`ifdef BPU_STATS_EN
  logic [15:0] stat_upd, stat_mis, n_su, n_sm;
`endif
  int checks = 0;
  int errors = 0;
  int m_tbl[DEPTH];
  int m_ghr, m_upd, m_mis;
  bit m_run;

  bpu_gshare_dual dut (
    .clk(clk), .reset(reset), .pc1(pc1), .pc2(pc2), .pc_f(pc_f),
    .pred1(pred1), .pred2(pred2), .pred_f(pred_f), .ghr_out(ghr_out),
    .upd1_en(upd1_en), .upd1_pc(upd1_pc), .upd1_ghr(upd1_ghr), .upd1_taken(upd1_taken),
    .upd2_en(upd2_en), .upd2_pc(upd2_pc), .upd2_ghr(upd2_ghr), .upd2_taken(upd2_taken),
    .ready(ready)
`ifdef BPU_STATS_EN
    , .stat_upd(stat_upd), .stat_mis(stat_mis)
`endif
  );

  bpu_gshare_dual #(.PC_W(4), .IDX_W(4), .CTR_W(3), .GHR_W(1)) u3 (
    .clk(clk), .reset(reset), .pc1(n_pc1), .pc2(n_pc2), .pc_f(n_pcf),
    .pred1(n_p1), .pred2(n_p2), .pred_f(n_pf), .ghr_out(n_ghr),
    .upd1_en(n_u1en), .upd1_pc(n_u1pc), .upd1_ghr(n_u1g), .upd1_taken(n_u1t),
    .upd2_en(n_u2en), .upd2_pc(n_u2pc), .upd2_ghr(n_u2g), .upd2_taken(n_u2t),
    .ready(n_ready)
`ifdef BPU_STATS_EN
    , .stat_upd(n_su), .stat_mis(n_sm)
`endif
  );

  function automatic int midx(int pc, int g);
    return (pc ^ g) % DEPTH;
  endfunction

  function automatic bit mpred(int pc);
    return m_run && (m_tbl[midx(pc, m_ghr)] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
    m_ghr = 0;
    m_upd = 0;
    m_mis = 0;
    m_run = 0;
  endtask

  // Applying slot 1 then slot 2 sequentially to the array models the same-index merge.
  task automatic model_clock();
    int i;
    if (!m_run) return;
    if (upd1_en) begin
      i = midx(upd1_pc, upd1_ghr);
      if (int'(upd1_taken) != int'(m_tbl[i] >= 2)) m_mis++;
      m_tbl[i] = upd1_taken ? ((m_tbl[i] == 3) ? 3 : m_tbl[i] + 1) : ((m_tbl[i] == 0) ? 0 : m_tbl[i] - 1);
      m_upd++;
    end
    if (upd2_en) begin
      i = midx(upd2_pc, upd2_ghr);
      if (int'(upd2_taken) != int'(m_tbl[i] >= 2)) m_mis++;
      m_tbl[i] = upd2_taken ? ((m_tbl[i] == 3) ? 3 : m_tbl[i] + 1) : ((m_tbl[i] == 0) ? 0 : m_tbl[i] - 1);
      m_upd++;
    end
    if (upd1_en && upd2_en) m_ghr = ((m_ghr * 4) + 2 * int'(upd1_taken) + int'(upd2_taken)) % 64;
    else if (upd1_en) m_ghr = ((m_ghr * 2) + int'(upd1_taken)) % 64;
    else if (upd2_en) m_ghr = ((m_ghr * 2) + int'(upd2_taken)) % 64;
    if (m_upd > 65535) m_upd = 65535;
    if (m_mis > 65535) m_mis = 65535;
  endtask

  task automatic idle();
    pc1 = '0; pc2 = '0; pc_f = '0;
    upd1_en = 0; upd2_en = 0; upd1_taken = 0; upd2_taken = 0;
    upd1_pc = '0; upd2_pc = '0; upd1_ghr = '0; upd2_ghr = '0;
  endtask

  task automatic n_idle();
    n_pc1 = '0; n_pc2 = '0; n_pcf = '0; n_u1pc = '0; n_u2pc = '0;
    n_u1g = '0; n_u2g = '0; n_u1en = 0; n_u2en = 0; n_u1t = 0; n_u2t = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic upd1(input logic [7:0] pc, input logic t);
    idle();
    upd1_en = 1; upd1_pc = pc; upd1_ghr = '0; upd1_taken = t;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    upd1_en = 1; upd1_taken = 1; upd2_en = 1; upd2_taken = 1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (ghr_out !== 6'd0) begin errors++; $display("FAIL reset_ghr got %h want 0", ghr_out); end
`ifdef BPU_STATS_EN
    checks++; if (stat_upd !== 16'd0 || stat_mis !== 16'd0) begin errors++; $display("FAIL reset_stats got %h/%h want 0/0", stat_upd, stat_mis); end
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pc1 = 8'($urandom); pc2 = 8'($urandom); pc_f = 8'($urandom);
      upd1_pc = 8'($urandom); upd2_pc = 8'($urandom); upd1_taken = 1'($urandom); upd2_taken = 1'($urandom);
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL init_ready cycle %0d got %b want 0", i, ready); end
      checks++; if ({pred1, pred2, pred_f} !== 3'b000) begin errors++; $display("FAIL init_pred cycle %0d got %b want 000", i, {pred1, pred2, pred_f}); end
      checks++; if (ghr_out !== 6'd0) begin errors++; $display("FAIL init_ghr cycle %0d got %h want 0", i, ghr_out); end
      @(negedge clk);
    end
    idle();
    #1;
    m_run = 1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_done_ready got %b want 1", ready); end
    checks++; if (pred_f !== 1'b0) begin errors++; $display("FAIL init_done_predf got %b want 0", pred_f); end
  endtask

  task automatic test_ghr_shift();
    upd1(8'h10, 1); tick();
    upd1(8'h10, 1); tick();
    idle(); pc1 = 8'h10; pc2 = 8'h13; #1;
    checks++; if (ghr_out !== 6'b000011) begin errors++; $display("FAIL ghr_two_taken got %b want 000011", ghr_out); end
    checks++; if (pred1 !== 1'b0) begin errors++; $display("FAIL ghr_fresh_entry got %b want 0", pred1); end
    checks++; if (pred2 !== 1'b1) begin errors++; $display("FAIL ghr_entry10_taken got %b want 1", pred2); end
    upd1(8'h10, 0); tick();
    idle(); pc2 = 8'h10 ^ 8'(m_ghr); #1;
    checks++; if (ghr_out !== 6'b000110) begin errors++; $display("FAIL ghr_shift_nt got %b want 000110", ghr_out); end
    checks++; if (pred2 !== 1'b1) begin errors++; $display("FAIL ghr_entry10_was_sat got %b want 1", pred2); end
  endtask

  task automatic test_same_index();
    int prev;
    prev = m_ghr;
    idle();
    upd1_en = 1; upd2_en = 1; upd1_pc = 8'h40; upd2_pc = 8'h40; upd1_taken = 1; upd2_taken = 0;
    tick();
    idle(); pc1 = 8'h40 ^ 8'(m_ghr); #1;
    checks++; if (ghr_out !== 6'(((prev * 4) + 2) % 64)) begin errors++; $display("FAIL same_ghr got %h want %h", ghr_out, 6'(((prev * 4) + 2) % 64)); end
    checks++; if (pred1 !== 1'b0) begin errors++; $display("FAIL same_merge_tn got %b want 0", pred1); end
    upd1(8'h40, 1); tick();
    idle(); pc1 = 8'h40 ^ 8'(m_ghr); #1;
    checks++; if (pred1 !== 1'b1) begin errors++; $display("FAIL same_merge_back01 got %b want 1", pred1); end
    idle();
    upd1_en = 1; upd2_en = 1; upd1_pc = 8'h41; upd2_pc = 8'h41; upd1_taken = 0; upd2_taken = 1;
    tick();
    upd1(8'h41, 1); tick();
    idle(); pc1 = 8'h41 ^ 8'(m_ghr); #1;
    checks++; if (pred1 !== 1'b1) begin errors++; $display("FAIL same_merge_nt got %b want 1", pred1); end
    idle();
    upd1_en = 1; upd2_en = 1; upd1_pc = 8'h50; upd2_pc = 8'h51; upd1_taken = 1; upd2_taken = 1;
    tick();
    idle(); pc1 = 8'h50 ^ 8'(m_ghr); pc2 = 8'h51 ^ 8'(m_ghr); #1;
    checks++; if ({pred1, pred2} !== 2'b11) begin errors++; $display("FAIL diff_index got %b want 11", {pred1, pred2}); end
  endtask

  task automatic test_saturation();
    repeat (4) begin upd1(8'h60, 1); tick(); end
    idle(); pc1 = 8'h60 ^ 8'(m_ghr); #1;
    checks++; if (pred1 !== 1'b1) begin errors++; $display("FAIL sat_hi got %b want 1", pred1); end
    upd1(8'h60, 0); tick();
    idle(); pc1 = 8'h60 ^ 8'(m_ghr); #1;
    checks++; if (pred1 !== 1'b1) begin errors++; $display("FAIL sat_hi_hold got %b want 1", pred1); end
    repeat (4) begin upd1(8'h60, 0); tick(); end
    upd1(8'h60, 1); tick();
    idle(); pc1 = 8'h60 ^ 8'(m_ghr); #1;
    checks++; if (pred1 !== 1'b0) begin errors++; $display("FAIL sat_lo_hold got %b want 0", pred1); end
  endtask

  task automatic test_rbw();
    upd1(8'h70, 1);
    pc1 = 8'h70 ^ 8'(m_ghr); pc_f = pc1; #1;
    checks++; if ({pred1, pred_f} !== 2'b00) begin errors++; $display("FAIL rbw_old got %b want 00", {pred1, pred_f}); end
    tick();
    idle(); pc1 = 8'h70 ^ 8'(m_ghr); pc_f = pc1; #1;
    checks++; if ({pred1, pred_f} !== 2'b11) begin errors++; $display("FAIL rbw_new got %b want 11", {pred1, pred_f}); end
  endtask

  task automatic rand_cycle(input bit check);
    upd1_en = 1'($urandom); upd2_en = 1'($urandom);
    upd1_taken = 1'($urandom); upd2_taken = 1'($urandom);
    upd1_pc = 8'($urandom_range(0, 15)); upd2_pc = 8'($urandom_range(0, 15));
    upd1_ghr = $urandom_range(0, 1) ? 6'(m_ghr) : 6'($urandom_range(0, 3));
    upd2_ghr = $urandom_range(0, 1) ? 6'(m_ghr) : 6'($urandom_range(0, 3));
    pc1 = 8'($urandom_range(0, 15) ^ m_ghr); pc2 = 8'($urandom); pc_f = 8'($urandom_range(0, 15) ^ m_ghr);
    #1;
    if (check) begin
      checks++; if (pred1 !== mpred(pc1)) begin errors++; $display("FAIL rand_pred1 pc %h got %b want %b", pc1, pred1, mpred(pc1)); end
      checks++; if (pred2 !== mpred(pc2)) begin errors++; $display("FAIL rand_pred2 pc %h got %b want %b", pc2, pred2, mpred(pc2)); end
      checks++; if (pred_f !== mpred(pc_f)) begin errors++; $display("FAIL rand_predf pc %h got %b want %b", pc_f, pred_f, mpred(pc_f)); end
      checks++; if (ghr_out !== 6'(m_ghr)) begin errors++; $display("FAIL rand_ghr got %h want %h", ghr_out, 6'(m_ghr)); end
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) rand_cycle(1);
    idle(); #1;
    checks++; if (ghr_out !== 6'(m_ghr)) begin errors++; $display("FAIL rand_final_ghr got %h want %h", ghr_out, 6'(m_ghr)); end
`ifdef BPU_STATS_EN
    checks++; if (stat_upd !== 16'(m_upd)) begin errors++; $display("FAIL stat_upd got %0d want %0d", stat_upd, m_upd); end
    checks++; if (stat_mis !== 16'(m_mis)) begin errors++; $display("FAIL stat_mis got %0d want %0d", stat_mis, m_mis); end
`endif
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 50; i++) rand_cycle(0);
    test_reset();
    for (int i = 0; i < 40; i++) rand_cycle(1);
    idle();
  endtask

  task automatic test_narrow();
    int v, g;
    v = 3;
    g = int'(n_ghr);
    for (int i = 0; i < 9; i++) begin
      n_idle();
      n_u1en = 1; n_u1pc = 4'd5; n_u1g = 1'b0; n_u1t = (i < 5);
      @(posedge clk);
      v = (i < 5) ? ((v == 7) ? 7 : v + 1) : ((v == 0) ? 0 : v - 1);
      g = (i < 5) ? 1 : 0;
      @(negedge clk);
      n_idle(); n_pc1 = 4'(5 ^ g); #1;
      checks++; if (n_p1 !== (v >= 4)) begin errors++; $display("FAIL narrow_ctr step %0d got %b want %b", i, n_p1, v >= 4); end
      checks++; if (n_ghr !== 1'(g)) begin errors++; $display("FAIL narrow_ghr1 step %0d got %b want %b", i, n_ghr, 1'(g)); end
    end
    n_idle();
    n_u1en = 1; n_u2en = 1; n_u1pc = 4'd9; n_u2pc = 4'd10; n_u1t = 1; n_u2t = 0;
    @(negedge clk); n_idle(); #1;
    checks++; if (n_ghr !== 1'b0) begin errors++; $display("FAIL narrow_both_t2_0 got %b want 0", n_ghr); end
    n_u1en = 1; n_u2en = 1; n_u1pc = 4'd9; n_u2pc = 4'd10; n_u1t = 0; n_u2t = 1;
    @(negedge clk); n_idle(); #1;
    checks++; if (n_ghr !== 1'b1) begin errors++; $display("FAIL narrow_both_t2_1 got %b want 1", n_ghr); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    n_idle();
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_ghr_shift();
    test_same_index();
    test_saturation();
    test_rbw();
    test_random();
    test_mid_reset();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpu_gshare_dual.md
Name: bpu_gshare_dual

Overview:
Parametrised dual-issue gshare branch predictor. Successor to the per-PC 2-bit bimodal BHT.
- Adds a global history register (GHR), configurable table depth and counter width, a sequential table-init FSM, and same-cycle same-index update merging.
- Sits between fetch (instruction-memory prediction) and decode (two issue-slot predictions); it is updated from the Memory stage.

Parameters:
PC_W, 8, width of every PC input (must be >= IDX_W)
IDX_W, 8, table index width; depth = 2**IDX_W entries
CTR_W, 2, saturating counter width (>= 2)
GHR_W, 6, global history length (1..IDX_W)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pc1  in  PC_W  slot-1 lookup PC
pc2  in  PC_W  slot-2 lookup PC
pc_f  in  PC_W  fetch lookup PC (nextPC)
pred1  out  1  slot-1 taken prediction
pred2  out  1  slot-2 taken prediction
pred_f  out  1  fetch taken prediction
ghr_out  out  GHR_W  current GHR; the pipeline carries it with each branch as its snapshot
upd1_en  in  1  slot-1 resolved branch valid (M stage)
upd1_pc  in  PC_W  slot-1 branch PC
upd1_ghr  in  GHR_W  GHR snapshot taken when slot-1 was predicted
upd1_taken  in  1  slot-1 outcome
upd2_en, upd2_pc, upd2_ghr, upd2_taken: same as slot 1, for slot 2 (program-order younger)
ready  out  1  table initialised; predictions valid

Behaviour:
- Index hash: idx(pc, g) = pc[IDX_W-1:0] XOR zero-extend(g).
- Lookups use the current GHR. Predictions are combinational: pred = counter MSB.
- Read-before-write: a lookup in the same cycle as an update to that index returns the pre-update value.
- Init value INIT_V = 2**(CTR_W-1) - 1 (weakly not-taken; 01 for CTR_W = 2).
- FSM states: INIT and RUN.
  - Reset asserted: state = INIT, init pointer = 0, GHR = 0, ready = 0.
  - INIT: one entry is written with INIT_V per cycle, pointer incrementing. When pointer = 2**IDX_W - 1 is written, go to RUN next cycle with ready = 1. INIT lasts exactly 2**IDX_W cycles after reset release.
  - In INIT: pred1/pred2/pred_f are forced to 0; update ports are ignored; GHR is held at 0.
  - RUN: stays in RUN until reset.
  - Reset mid-INIT or mid-RUN restarts INIT from pointer 0.
- Counter update (RUN only): taken -> +1, saturating at 2**CTR_W - 1; not-taken -> -1, saturating at 0.
  - Slot 1 writes entry idx(upd1_pc, upd1_ghr); slot 2 writes entry idx(upd2_pc, upd2_ghr).
  - Both enabled, same index: apply slot-1 step, then slot-2 step to that result, in one write. For example, 3 with taken then not-taken gives 2; 0 with not-taken then taken gives 1.
  - Both enabled, different indices: independent writes.
- GHR update (RUN, non-speculative, at update time), newest outcome in the LSB:
  - Only slot 1 enabled: ghr <= {ghr[GHR_W-2:0], t1}.
  - Only slot 2 enabled: ghr <= {ghr[GHR_W-2:0], t2}.
  - Both enabled: ghr <= {ghr[GHR_W-3:0], t1, t2}.
  - GHR_W = 1 with both enabled: ghr <= t2.
  - Neither enabled: hold.
- Update latency: the new counter and GHR are visible to lookups the cycle after upd*_en.
- ghr_out reset value 0. ready reset value 0.

Optional Feature:
Macro BPU_STATS_EN.
- Defined: adds outputs stat_upd (16 bits) and stat_mis (16 bits), both reset to 0, both saturating at 16'hFFFF, both counting only in RUN.
  - stat_upd adds the number of enabled update ports each cycle (0, 1 or 2).
  - stat_mis adds 1 per enabled update whose outcome differs from the MSB of its table entry before this cycle's update. For a same-index pair, slot 2 compares against the slot-1-updated value.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, IDX_W = 8 -> ready = 0 for 256 cycles, then 1. Every pred = 0 during INIT. After INIT, pred_f = 0 and an entry read returns 01.
- RUN, GHR = 0, upd1 pc = 8'h10 taken twice -> ghr_out = 6'b000011. Lookup pc1 = 8'h10 with current GHR hits a fresh entry: pred1 = 0. Entry 8'h10 holds 11.
- Same-cycle upd1/upd2 to the same index, entry 01, t1 = 1, t2 = 0 -> entry back to 01. GHR gains bits 1,0 (shift by 2).
- Saturation: entry 11 plus taken -> stays 11; entry 00 plus not-taken -> stays 00. With CTR_W = 3, five taken steps from 011 -> 111.
- Lookup and update to the same index in the same cycle -> pred reflects the old counter; the next cycle reflects the new counter.
- Reset pulsed 50 cycles into RUN -> GHR = 0, ready = 0, full 2**IDX_W-cycle INIT reruns. With BPU_STATS_EN defined, stat_upd and stat_mis = 0.
